ldpc_enc: RTL and testbench
===========================

LDPC_ENC -- requirements
Module: ldpc_enc

Interface
REQ-001 Parameter K, default 8, message bits per codeword.
REQ-002 Parameter M, default 8, parity bits per codeword; N = K+M = 16.
REQ-003 The block SHALL use one clock, clk; reset is synchronous and active-high, named rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 msg_in  input  K  message word; bit 0 is the first systematic bit.
REQ-007 msg_valid  input  1  msg_in is valid.
REQ-008 msg_ready  output  1  the block can accept a message.
REQ-009 cw_bit  output  1  serial codeword bit.
REQ-010 cw_valid  output  1  cw_bit is valid.
REQ-011 cw_ready  input  1  the downstream BF decoder accepts cw_bit.
REQ-012 cw_last  output  1  marks codeword bit N-1.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Code definition: codeword c = {m, p}, where p = XOR over k of (m[k] ? P_COL[k] : 0) and P_COL[k] = rotate-left(8'b00001011, k); the matching parity-check matrix is H = [P^T | I].
REQ-015 The FSM SHALL have three states:
- IDLE: msg_ready=1; on msg_valid&&msg_ready, capture msg_in into msg_reg, clear parity_reg, set cnt=0, go to ENC.
- ENC: each cycle, parity_reg ^= msg_reg[cnt] ? P_COL[cnt] : 0, and cnt++; when cnt==K-1 is processed, set idx=0 and go to SEND.
- SEND: cw_valid=1; cw_bit = msg_reg[idx] for idx<K, else parity_reg[idx-K]; on cw_valid&&cw_ready, idx++.
- SEND exit: a handshake with idx==N-1 goes to IDLE.
REQ-016 Latency: if the message is accepted at edge E0, ENC spans edges E1..E8 and cw_valid is first high after E8.
REQ-017 cw_last SHALL equal cw_valid && idx==N-1.
REQ-018 While cw_valid=1 and cw_ready=0, cw_bit, cw_last and idx SHALL hold stable indefinitely.
REQ-019 msg_ready SHALL be 0 in ENC and SEND; msg_valid there is ignored and never captured.
REQ-020 Back-to-back: the cycle after the last-bit handshake, the state is IDLE and msg_ready=1; no message is accepted in the same cycle as the last-bit handshake.
REQ-021 cnt and idx SHALL be ceil(log2(N)) bits wide and never wrap inside a codeword; all parity arithmetic is GF(2) XOR at width M.
REQ-022 Output reset values: msg_ready=1 after reset completes, and cw_bit=0, cw_valid=0, cw_last=0, busy=0.

Reset
REQ-023 rst sampled high at a clk edge SHALL force IDLE and clear msg_reg, parity_reg, cnt and idx.
REQ-024 rst asserted mid-ENC or mid-SEND SHALL abort the codeword with no further cw_valid; rst has priority over every handshake in the same cycle.

Structure
REQ-025 K, M, N, the P_COL constant array and the state enum (IDLE, ENC, SEND) SHALL live in the shared package ldpc_pkg, which is also used by the decoder.
REQ-026 One sub-module, ldpc_enc_par (parity accumulator: clear, enable, bit index -> parity_reg), is natural; the FSM and serializer remain in ldpc_enc.

Verification
REQ-027 msg_in=8'h01 with cw_ready=1 -> serial stream 1,0,0,0,0,0,0,0 then parity 0x0B LSB-first (1,1,0,1,0,0,0,0); cw_last on the 16th bit; first cw_valid after 8 ENC cycles.
REQ-028 msg_in=8'h03 -> parity 0x1D; msg_in=8'hFF -> parity 0xFF; msg_in=8'h00 -> all 16 bits 0.
REQ-029 With cw_ready toggled pseudo-randomly, msg 8'hA5 -> a 16-bit stream identical to the cw_ready=1 case, with outputs stable during stalls.
REQ-030 msg_valid held high continuously -> a new message is accepted exactly once per codeword, only while msg_ready=1, with one IDLE cycle between codewords.
REQ-031 rst pulsed for one cycle at SEND idx=5 -> cw_valid=0 and busy=0 the next cycle, and msg_ready=1; the next message encodes correctly.
REQ-032 Scoreboard: for every emitted codeword c, H·c^T = 0, checked over 256 random messages.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared LDPC code constants: code dimensions, parity column table and FSM state encoding.
// Used by both the encoder and the bit-flipping decoder.
package ldpc_pkg;

   localparam int K  = 8;
   localparam int M  = 8;
   localparam int N  = K + M;
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE,
      ENC,
      SEND
   } state_t;

   // Column k of P is 8'b00001011 rotated left by k; H = [P^T | I].
   localparam logic [M-1:0] P_COL [K] = '{
      8'h0B, 8'h16, 8'h2C, 8'h58, 8'hB0, 8'h61, 8'hC2, 8'h85
   };

endpackage

// File: rtl/ldpc_enc_par.sv
// Parity accumulator: folds one message bit per enabled cycle into the GF(2) parity word.
module ldpc_enc_par #(
   parameter int K = ldpc_pkg::K,
   parameter int M = ldpc_pkg::M
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 msg_bit,
   input  logic [$clog2(K)-1:0] bit_idx,
   output logic [M-1:0]         parity
);

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         parity <= '0;
      end else if (en && msg_bit) begin
         parity <= parity ^ ldpc_pkg::P_COL[bit_idx];
      end
   end

endmodule

// File: rtl/ldpc_enc.sv
// Systematic LDPC encoder: captures a K-bit message, accumulates M parity bits over K cycles,
// then streams the N-bit codeword {parity, message} LSB-first under a valid/ready handshake.
module ldpc_enc #(
   parameter int K = ldpc_pkg::K,
   parameter int M = ldpc_pkg::M
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [K-1:0] msg_in,
   input  logic         msg_valid,
   output logic         msg_ready,
   output logic         cw_bit,
   output logic         cw_valid,
   input  logic         cw_ready,
   output logic         cw_last,
   output logic         busy
);

   import ldpc_pkg::state_t;
   import ldpc_pkg::IDLE;
   import ldpc_pkg::ENC;
   import ldpc_pkg::SEND;

   localparam int N  = K + M;
   localparam int CW = $clog2(N);
   localparam int KW = $clog2(K);
   localparam int MW = $clog2(M);

   state_t         state, state_nxt;
   logic [K-1:0]   msg_reg;
   logic [M-1:0]   parity_reg;
   logic [CW-1:0]  cnt, idx;
   logic [MW-1:0]  par_idx;
   logic           accept, enc_last, send_last, sel_bit;

   assign accept    = (state == IDLE) && msg_valid;
   assign enc_last  = (cnt == CW'(K - 1));
   assign send_last = (idx == CW'(N - 1));
   assign par_idx   = MW'(idx - CW'(K));
   assign sel_bit   = (idx < CW'(K)) ? msg_reg[idx[KW-1:0]] : parity_reg[par_idx];

   ldpc_enc_par #(.K(K), .M(M)) u_par (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .en      (state == ENC),
      .msg_bit (msg_reg[cnt[KW-1:0]]),
      .bit_idx (cnt[KW-1:0]),
      .parity  (parity_reg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (msg_valid)             state_nxt = ENC;
         ENC:     if (enc_last)              state_nxt = SEND;
         SEND:    if (cw_ready && send_last) state_nxt = IDLE;
         default:                            state_nxt = IDLE;
      endcase
   end

   // Counters saturate at their terminal value rather than wrapping mid-codeword.
   always_ff @(posedge clk) begin
      if (rst) begin
         msg_reg <= '0;
         cnt     <= '0;
         idx     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (msg_valid) begin
                  msg_reg <= msg_in;
                  cnt     <= '0;
               end
            end
            ENC: begin
               cnt <= cnt + 1'b1;
               if (enc_last) idx <= '0;
            end
            SEND: begin
               if (cw_ready && !send_last) idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      msg_ready = 1'b0;
      cw_valid  = 1'b0;
      cw_bit    = 1'b0;
      cw_last   = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            msg_ready = 1'b1;
            busy      = 1'b0;
         end
         SEND: begin
            cw_valid = 1'b1;
            cw_bit   = sel_bit;
            cw_last  = send_last;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ldpc_enc.sv
// Self-checking bench for ldpc_enc: directed steps plus a codeword scoreboard fed at message acceptance.
module tb_ldpc_enc;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] msg_in;
   logic       msg_valid;
   logic       msg_ready;
   logic       cw_bit;
   logic       cw_valid;
   logic       cw_ready;
   logic       cw_last;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;
   int bit_pos  = 0;
   int n_cw     = 0;
   int n_acc    = 0;
   logic        rand_ready = 1'b0;
   logic        after_last = 1'b0;
   logic [15:0] rx;
   logic [15:0] last_cw = '0;
   logic [15:0] sb_q [$];

   ldpc_enc dut (
      .clk       (clk),
      .rst       (rst),
      .msg_in    (msg_in),
      .msg_valid (msg_valid),
      .msg_ready (msg_ready),
      .cw_bit    (cw_bit),
      .cw_valid  (cw_valid),
      .cw_ready  (cw_ready),
      .cw_last   (cw_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] model_par(input logic [7:0] m);
      logic [7:0] p    = '0;
      logic [7:0] base = 8'b0000_1011;
      logic [7:0] col;
      for (int k = 0; k < 8; k++) begin
         col = (base << k) | (base >> (8 - k));
         if (m[k]) p ^= col;
      end
      return p;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         cw_ready = 1'($urandom_range(0, 1));
      end
   end

   // Scoreboard: push at acceptance, compare every valid bit against the front codeword.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         bit_pos    = 0;
         after_last = 1'b0;
      end else begin
         if (after_last) begin
            check("idle_after_last_ready", msg_ready, 1);
            check("idle_after_last_busy", busy, 0);
            after_last = 1'b0;
         end
         if (cw_valid) begin
            check("ready_low_in_send", msg_ready, 0);
            if (sb_q.size() == 0) begin
               check("unexpected_cw", cw_valid, 0);
            end else begin
               check("cw_bit", cw_bit, sb_q[0][bit_pos]);
               check("cw_last", cw_last, (bit_pos == 15));
               if (cw_ready) begin
                  rx[bit_pos] = cw_bit;
                  if (bit_pos == 15) begin
                     void'(sb_q.pop_front());
                     check("syndrome", model_par(rx[7:0]) ^ rx[15:8], 0);
                     last_cw    = rx;
                     n_cw++;
                     bit_pos    = 0;
                     after_last = 1'b1;
                  end else begin
                     bit_pos++;
                  end
               end
            end
         end
         if (msg_valid && msg_ready) begin
            sb_q.push_back({model_par(msg_in), msg_in});
            n_acc++;
         end
      end
   end

   task automatic send(input logic [7:0] m);
      int b = 0;
      while (!msg_ready && b < 200) begin
         @(posedge clk); #1;
         b++;
      end
      check("send_ready_timeout", msg_ready, 1);
      msg_in    = m;
      msg_valid = 1'b1;
      @(posedge clk); #1;
      msg_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int b = 0;
      while ((busy || sb_q.size() != 0) && b < 400) begin
         @(posedge clk); #1;
         b++;
      end
      check("idle_timeout", busy, 0);
   endtask

   initial begin
      int cyc;
      int acc0;
      int cw0;
      int b;

      rst       = 1'b1;
      msg_in    = '0;
      msg_valid = 1'b0;
      cw_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_msg_ready", msg_ready, 1);
      check("rst_cw_valid", cw_valid, 0);
      check("rst_cw_bit", cw_bit, 0);
      check("rst_cw_last", cw_last, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1;

      // Single-bit message: latency and stream shape.
      send(8'h01);
      cyc = 0;
      while (cyc < 20) begin
         @(negedge clk);
         if (cw_valid) break;
         check("enc_busy", busy, 1);
         cyc++;
      end
      check("first_valid_latency", cyc, 8);
      wait_idle();
      check("cw_01", last_cw, 16'h0B01);

      send(8'h03);
      wait_idle();
      check("cw_03", last_cw, 16'h1D03);
      send(8'hFF);
      wait_idle();
      check("cw_ff", last_cw, 16'hFFFF);
      send(8'h00);
      wait_idle();
      check("cw_00", last_cw, 16'h0000);

      // Back-pressure: random stalls must not disturb the stream.
      rand_ready = 1'b1;
      send(8'hA5);
      wait_idle();
      rand_ready = 1'b0;
      @(posedge clk); #1;
      cw_ready = 1'b1;
      check("cw_a5_stalled", last_cw, 16'hC3A5);

      // Continuous msg_valid: one acceptance per 25-cycle codeword slot.
      acc0      = n_acc;
      cw0       = n_cw;
      msg_valid = 1'b1;
      for (int i = 0; i < 75; i++) begin
         msg_in = 8'($urandom);
         @(posedge clk); #1;
      end
      msg_valid = 1'b0;
      check("continuous_accepts", n_acc - acc0, 3);
      wait_idle();
      check("continuous_codewords", n_cw - cw0, 3);

      // Reset mid-SEND aborts the codeword.
      send(8'h77);
      b = 0;
      while (!(cw_valid && bit_pos == 5) && b < 200) begin
         @(posedge clk); #1;
         b++;
      end
      check("reach_idx5", bit_pos, 5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_cw_valid", cw_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_msg_ready", msg_ready, 1);
      @(posedge clk); #1;
      send(8'h5A);
      wait_idle();
      check("cw_5a_after_abort", last_cw, 16'h3C5A);

      // Random messages, the first batch with random back-pressure.
      cw0 = n_cw;
      for (int i = 0; i < 256; i++) begin
         rand_ready = (i < 32);
         send(8'($urandom));
      end
      wait_idle();
      rand_ready = 1'b0;
      check("random_codewords", n_cw - cw0, 256);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
